// File: rtl/disp_param_scheduler.sv
// Chooses which wave-generator parameter the 4-digit display shows: home view,
// manual stepping via next_btn, or a blinking hold after a parameter change.
module disp_param_scheduler #(
    parameter int unsigned HOLD_CYCLES  = 300_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000,
    parameter int unsigned HOME_MODE    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] freq_val,
    input  logic [15:0] phase_val,
    input  logic [15:0] duty_val,
    input  logic [15:0] swp_rng_val,
    input  logic [15:0] swp_spd_val,
    input  logic [4:0]  chg,
    input  logic        next_btn,
    input  logic        auto_return,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_mode,
    output logic        blank,
    output logic        upd
);

    generate
        if (HOLD_CYCLES < 2) begin : g_bad_hold
            $error("HOLD_CYCLES must be at least 2");
        end
        if (BLINK_CYCLES < 2) begin : g_bad_blink
            $error("BLINK_CYCLES must be at least 2");
        end
        if (HOME_MODE > 4) begin : g_bad_home
            $error("HOME_MODE must be in 0..4");
        end
    endgenerate

    typedef enum logic [1:0] {ST_HOME, ST_MANUAL, ST_HOLD} state_t;

    localparam logic [3:0]  HOME_IDX   = 4'(HOME_MODE);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  mode_n;
    logic [3:0]  step_mode;
    logic [31:0] timer, timer_n;
    logic [31:0] blink_cnt, blink_cnt_n;
    logic        blank_n;
    logic [15:0] value_n;

    // Lowest set bit wins, so frequency changes take precedence.
    function automatic logic [3:0] lowest_index(input logic [4:0] v);
        lowest_index = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) lowest_index = 4'(i);
        end
    endfunction

    always_comb begin
        state_n     = state;
        mode_n      = disp_mode;
        timer_n     = timer;
        blink_cnt_n = '0;
        blank_n     = 1'b0;
        step_mode   = (disp_mode == 4'd4) ? 4'd0 : disp_mode + 4'd1;

        if (chg != 5'd0) begin
            state_n = ST_HOLD;
            mode_n  = lowest_index(chg);
            timer_n = '0;
        end else if (next_btn) begin
            mode_n  = step_mode;
            state_n = (step_mode == HOME_IDX) ? ST_HOME : ST_MANUAL;
            timer_n = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (timer == HOLD_LAST) begin
                        state_n = ST_HOME;
                        mode_n  = HOME_IDX;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 32'd1;
                        blank_n = blank;
                        if (blink_cnt == BLINK_LAST) begin
                            blank_n = ~blank;
                        end else begin
                            blink_cnt_n = blink_cnt + 32'd1;
                        end
                    end
                end
                ST_MANUAL: begin
                    if (!auto_return) begin
                        timer_n = '0;
                    end else if (timer == HOLD_LAST) begin
                        state_n = ST_HOME;
                        mode_n  = HOME_IDX;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 32'd1;
                    end
                end
                default: timer_n = '0;
            endcase
        end
    end

    // Value follows the mode being entered, so it lines up with disp_mode.
    always_comb begin
        case (mode_n)
            4'd0:    value_n = freq_val;
            4'd1:    value_n = phase_val;
            4'd2:    value_n = duty_val;
            4'd3:    value_n = swp_rng_val;
            default: value_n = swp_spd_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOME;
            disp_mode  <= HOME_IDX;
            disp_value <= '0;
            blank      <= 1'b0;
            upd        <= 1'b0;
            timer      <= '0;
            blink_cnt  <= '0;
        end else begin
            state      <= state_n;
            disp_mode  <= mode_n;
            disp_value <= value_n;
            blank      <= blank_n;
            upd        <= (mode_n != disp_mode);
            timer      <= timer_n;
            blink_cnt  <= blink_cnt_n;
        end
    end

endmodule

// File: doc/disp_param_scheduler.md
# disp_param_scheduler

Sequences what the 4-digit 7-segment display shows. It sits between the wave generator's five parameter registers (frequency, phase, duty, sweep range, sweep speed) and the display controller, and drives that controller's 16-bit value and 4-bit mode inputs. Parameter-change strobes, a user "next" button pulse and a return-to-home timer decide which parameter is shown. During a change hold the digits blink.

## Interface
- HOLD_CYCLES, 300_000_000: cycles a changed or manually selected parameter stays up before returning home (3 s at 100 MHz)
- BLINK_CYCLES, 25_000_000: half-period of the blink during change hold
- HOME_MODE, 0: mode index shown at rest (0..4)

- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- freq_val  in  16  mode 0 source
- phase_val  in  16  mode 1 source
- duty_val  in  16  mode 2 source
- swp_rng_val  in  16  mode 3 source
- swp_spd_val  in  16  mode 4 source
- chg  in  5  one-cycle change strobes; bit i means source i was modified
- next_btn  in  1  debounced one-cycle pulse that steps the mode manually
- auto_return  in  1  when 1, MANUAL also times out to home
- disp_value  out  16  registered value to the display controller
- disp_mode  out  4  registered mode index, 0..4; upper values never driven
- blank  out  1  1 = display blanked (blink off-phase)
- upd  out  1  one-cycle pulse whenever disp_mode changes

## Operation
- Reset values: state HOME, disp_mode=HOME_MODE, disp_value=0, blank=0, upd=0, hold timer=0, blink counter=0, blink phase visible.
- States:
  - HOME: shows HOME_MODE.
  - MANUAL: shows the user-selected mode.
  - HOLD: shows the most recently changed parameter.
- Source selection and priority:
  - Selected mode is the lowest set index of chg; freq has the highest priority.
  - chg has priority over next_btn in the same cycle; the button pulse is dropped.
- Any state, chg != 0:
  - go to HOLD with disp_mode = winning index.
  - Clear the hold timer; restart the blink at the visible phase.
  - A chg during HOLD retargets and restarts the timer, including the same index.
- next_btn with chg=0:
  - mode_next = (disp_mode==4) ? 0 : disp_mode+1.
  - Go to HOME if mode_next==HOME_MODE, else MANUAL.
  - Clear the timer.
  - From HOLD, the step starts from the held mode.
- HOLD timeout: the timer counts every cycle. At HOLD_CYCLES-1, go to HOME with disp_mode=HOME_MODE.
- MANUAL timeout:
  - When auto_return=1, the timer counts and times out to HOME identically.
  - When auto_return=0, the timer holds at 0 and MANUAL persists.
- blink: toggles only in HOLD. The blink counter wraps at BLINK_CYCLES-1 and flips blank. blank is forced 0 in HOME and MANUAL and on leaving HOLD.
- disp_value:
  - Registered every cycle from the source selected by the next-cycle mode.
  - It tracks live source changes with 1-cycle latency, even without chg.
- upd: pulses 1 the cycle after any edge that changes disp_mode. Retargeting HOLD to the same index gives no upd.
- Counters are 32-bit unsigned. Parameters must be at least 2, checked at elaboration.

## Timing
- chg or next_btn sampled at edge N: disp_mode, disp_value and state are valid after edge N; upd is high for cycle N..N+1.
- Source value change at edge N: reflected in disp_value after edge N+1.
- HOLD entered at edge N: return to HOME at edge N+HOLD_CYCLES, with no intervening events.
- First blank=1 at edge N+BLINK_CYCLES after HOLD entry.
- rst asserted mid-HOLD: all outputs return to reset values immediately (asynchronous). After release, first state activity is on the first clk edge.

## Test plan
Run with HOLD_CYCLES=20, BLINK_CYCLES=4, HOME_MODE=0.
- Reset, freq_val=0x1234 -> disp_mode=0, disp_value=0x1234 one cycle after the first edge, blank=0, upd=0.
- chg=5'b00100, duty_val=50 -> disp_mode=2, disp_value=50, upd for 1 cycle.
  - blank toggles every 4 cycles.
  - Back to mode 0 exactly 20 cycles after entry, blank=0.
- chg=5'b11010 -> mode 1 wins.
  - chg=5'b00010 again at hold cycle 15 -> timer restarts, no upd, home reached 20 cycles after the second strobe.
- next_btn x5 with auto_return=0 -> modes 1,2,3,4,0.
  - Wait 100 cycles in mode 3 -> stays 3.
  - Repeat with auto_return=1 -> returns to 0 after 20 cycles.
- next_btn and chg=5'b10000 on the same edge -> disp_mode=4 (HOLD), button ignored.
- rst pulsed mid-HOLD, asynchronously between edges -> disp_mode=0, blank=0, disp_value=0 immediately.
